imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer-side counterpart of the read-only instruction RAM.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word into the RAM write port at consecutive word addresses starting at 0.
- Used at boot or under test to load a program before the core is released.

Parameters:
- ADDR_W, 9: word-address width of the target RAM.
- DATA_W, 32: word width; fixed to 32, with 4 bytes per word.
- DEPTH, 512: maximum word count, 2**ADDR_W.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  single-cycle load request; sampled only in IDLE.
- len_i  in  ADDR_W+1  number of words to load (0..DEPTH); sampled with start_i.
- abort_i  in  1  cancels a load in progress.
- byte_valid_i  in  1  source has a byte.
- byte_i  in  8  stream byte.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- we_o  out  1  RAM write enable.
- wa_o  out  ADDR_W  RAM word address.
- wd_o  out  DATA_W  RAM write data.
- busy_o  out  1  a load is in progress.
- done_o  out  1  one-cycle pulse when a load completes.
- err_o  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- All outputs are registered. During reset (rst=0) every output is 0, the state is IDLE, and the word counter, byte counter and assembly register are 0.
- State IDLE
  - byte_ready_o=0, busy_o=0.
  - start_i=1 with len_i in 1..DEPTH: latch len, clear err_o, go to RECV.
  - start_i=1 with len_i=0: clear err_o, go to DONE with no writes.
  - start_i=1 with len_i>DEPTH: set err_o, stay in IDLE with no writes.
- State RECV
  - byte_ready_o=1, busy_o=1.
  - A byte is accepted on an edge where byte_valid_i and byte_ready_o are both 1.
  - Byte k (k=0..3) within a word goes to assembly bits [8k+7:8k].
  - On the edge accepting byte 3, go to WRITE.
  - byte_valid_i=0 is a stall: no state change and no timeout.
- State WRITE (exactly one cycle)
  - byte_ready_o=0, we_o=1, wa_o=word counter, wd_o=assembled word. The RAM captures the word on the closing edge.
  - Then the word counter increments. If the new count equals len, go to DONE; otherwise go to RECV with the byte counter at 0.
- State DONE (one cycle)
  - done_o=1, busy_o=1.
  - Then go to IDLE with the word counter cleared.
- Timing
  - we_o is asserted in the cycle immediately after the 4th byte handshake.
  - With byte_valid_i held at 1, throughput is 5 cycles per word.
  - A load of N words with continuous valid takes 5N cycles from entering RECV to entering DONE.
- wa_o holds its last value when we_o=0. wd_o is don't-care when we_o=0 but must be stable.
- Abort
  - abort_i=1 in RECV or WRITE takes priority over every other event.
  - Next state is IDLE, err_o=1, the partial word is discarded, and no further we_o.
  - If abort_i lands in the WRITE cycle, we_o is still 1 for that cycle: the write is already committed.
  - abort_i in IDLE or DONE is ignored.
- start_i while busy_o=1 is ignored.
- A byte presented in the same edge as abort_i is not accepted: ready drops on the next cycle and the byte is dropped.
- Reset asserted mid-load returns everything to reset values immediately (asynchronous) and suppresses any pending write.
- Word counter range is 0..DEPTH-1 for addresses. The final write goes to address len-1, so with len=DEPTH the last write is at 511 and the counter never wraps onto address 0.

Test Plan:
- Reset check: hold rst=0 while toggling inputs -> all outputs 0. Release, pulse start with len=2, stream bytes 78 56 34 12 EF BE AD DE with continuous valid -> writes (wa=0, wd=0x12345678) then (wa=1, wd=0xDEADBEEF); done_o pulses exactly once, 10 cycles after entering RECV; err_o stays 0.
- Stalled source: len=1, valid asserted every third cycle -> only 4 handshakes counted; single write wd=0x04030201 for bytes 01..04; we_o high exactly 1 cycle.
- Bounds:
  - len=0 -> done_o pulse, no we_o.
  - len=513 -> err_o=1, busy_o stays 0, no writes.
  - len=512 with a counting pattern -> last write at wa=511, no write to 0 afterwards; reading back through the RAM model, address i holds word i.
- Abort: len=3, abort_i after byte 6 -> exactly one write (wa=0), err_o=1, busy_o=0. A following start with len=1 clears err_o and writes at wa=0.
- Start while busy: pulse start with len=5 during a len=2 load -> ignored; exactly 2 writes.
- Async reset mid-load: drop rst between byte 2 and byte 3 -> outputs 0 in the same cycle, no we_o; a fresh load afterwards writes from wa=0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream loader bus: control/stream inputs from the boot master, RAM write
// port and status outputs from the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 9
);
  logic              start_i;
  logic [ADDR_W:0]   len_i;
  logic              abort_i;
  logic              byte_valid_i;
  logic [7:0]        byte_i;
  logic              byte_ready_o;
  logic              we_o;
  logic [ADDR_W-1:0] wa_o;
  logic [31:0]       wd_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  modport master (
    output start_i, len_i, abort_i, byte_valid_i, byte_i,
    input  byte_ready_o, we_o, wa_o, wd_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, len_i, abort_i, byte_valid_i, byte_i,
    output byte_ready_o, we_o, wa_o, wd_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction RAM loader: packs a little-endian byte stream into 32-bit words
// and writes them to consecutive word addresses starting at 0.
module imem_loader #(
  parameter int ADDR_W = 9
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);
  localparam int DATA_W = 32;
  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            state_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [ADDR_W:0]   wcnt_d;
  logic [1:0]        bcnt_q;
  logic [DATA_W-1:0] asm_q;
  logic              ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  assign wcnt_d = wcnt_q + 1'b1;

  assign bus.byte_ready_o = ready_q;
  assign bus.we_o         = we_q;
  assign bus.wa_o         = wa_q;
  assign bus.wd_o         = wd_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.len_i > DEPTH_W) begin
              err_q <= 1'b1;
            end else begin
              err_q  <= 1'b0;
              len_q  <= bus.len_i;
              wcnt_q <= '0;
              bcnt_q <= '0;
              busy_q <= 1'b1;
              if (bus.len_i == '0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= RECV;
                ready_q <= 1'b1;
              end
            end
          end
        end
        RECV: begin
          // Abort wins over a byte offered on the same edge; that byte is dropped.
          if (bus.abort_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            bcnt_q  <= '0;
          end else if (bus.byte_valid_i) begin
            asm_q[{bcnt_q, 3'b000} +: 8] <= bus.byte_i;
            bcnt_q <= bcnt_q + 1'b1;
            if (bcnt_q == 2'd3) begin
              state_q <= WRITE;
              ready_q <= 1'b0;
              we_q    <= 1'b1;
              wa_q    <= wcnt_q[ADDR_W-1:0];
              wd_q    <= {bus.byte_i, asm_q[23:0]};
            end
          end
        end
        WRITE: begin
          // The write presented this cycle is already committed even on abort.
          if (bus.abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            bcnt_q  <= '0;
          end else begin
            wcnt_q <= wcnt_d;
            bcnt_q <= '0;
            if (wcnt_d == len_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RECV;
              ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          wcnt_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
